// File: rtl/cpu_pkg.sv
// Shared CPU-level types and constants.
// Used by the RAM arbiter and its picker.
package cpu_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   // One-deep return tag for an issued read
   typedef struct packed {
      logic valid;
      logic port;
   } ret_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
// Both ports share one rdata, qualified by rvalid.
interface ram_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req0, req1, we0, we1,
      output addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1,
      input  rdata
   );

   modport slave (
      input  req0, req1, we0, we1,
      input  addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1,
      output rdata
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way picker: fixed priority to port 1 in
// boot mode, otherwise alternate on ties.
module rr_pick2
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       boot_mode,
   input  logic       advance,
   output logic [1:0] win
);

   logic last_q;
   logic last_d;

   // Pick a one-hot winner; a tie goes to the port not served last
   always_comb begin
      win = 2'b00;
      if (req == 2'b01) begin
         win = 2'b01;
      end else if (req == 2'b10) begin
         win = 2'b10;
      end else if (req == 2'b11) begin
         if (boot_mode || (last_q == PORT_CPU)) begin
            win = 2'b10;
         end else begin
            win = 2'b01;
         end
      end
   end

   // Remember the served port only when a grant is issued
   always_comb begin
      last_d = last_q;
      if (advance) begin
         last_d = win[1];
      end
   end

   // Reset to port 1 so that port 0 wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= PORT_LDR;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous single-port RAM between
// the CPU core (port 0) and the loader (port 1).
module ram_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              boot_mode,
   ram_arbiter_if.slave      bus,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic [1:0]        win;
   logic              adv;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              en_q, en_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   ret_tag_t          tag_q, tag_d;

   assign adv = |win;

   rr_pick2 u_pick (
      .clk       (clk),
      .rst       (rst),
      .req       ({bus.req1, bus.req0}),
      .boot_mode (boot_mode),
      .advance   (adv),
      .win       (win)
   );

   // Mux the winner's command onto the RAM; idle keeps the bus
   always_comb begin
      gnt0_d  = win[0];
      gnt1_d  = win[1];
      en_d    = adv;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (win[1]) begin
         we_d    = bus.we1;
         addr_d  = bus.addr1;
         wdata_d = bus.wdata1;
      end else if (win[0]) begin
         we_d    = bus.we0;
         addr_d  = bus.addr0;
         wdata_d = bus.wdata0;
      end
   end

   // Tag a read as it reaches the RAM so rvalid meets its data
   always_comb begin
      tag_d.valid = en_q & ~we_q;
      tag_d.port  = gnt1_q ? PORT_LDR : PORT_CPU;
   end

   // Command and return registers
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         tag_q   <= '0;
      end else begin
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         tag_q   <= tag_d;
      end
   end

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.rvalid0 = tag_q.valid & (tag_q.port == PORT_CPU);
   assign bus.rvalid1 = tag_q.valid & (tag_q.port == PORT_LDR);
   assign bus.rdata   = ram_rdata;

   assign ram_en    = en_q;
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

endmodule
